// File: rtl/rr_arb_node.sv
// rr_arb_node: round-robin N:1 arbiter feeding one registered valid/ready output stage.
// Define RR_ARB_PKT_LOCK_EN to hold the grant on one requester until it presents its last beat.
module rr_arb_node #(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int IDXW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       valid_up_in,
    output logic [N-1:0]       ready_up_out,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid_down_out,
    input  logic               ready_down_in,
    output logic [IDXW-1:0]    grant_idx
`ifdef RR_ARB_PKT_LOCK_EN
    ,
    input  logic [N-1:0]       last_up_in,
    output logic               last_down_out
`endif
);
    logic [IDXW-1:0]  ptr_q, ptr_d, scan_w, w, idx_q;
    logic             scan_any, any, load_en, up_fire, valid_q;
    logic [WIDTH-1:0] data_q;

    // Scan from the highest offset down so the first valid index after ptr wins.
    always_comb begin
        logic [IDXW:0] s;
        s        = '0;
        scan_w   = '0;
        scan_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr_q} + (IDXW+1)'(k);
            s = (s >= (IDXW+1)'(N)) ? s - (IDXW+1)'(N) : s;
            if (valid_up_in[s[IDXW-1:0]]) begin
                scan_w   = s[IDXW-1:0];
                scan_any = 1'b1;
            end
        end
    end

`ifdef RR_ARB_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_e;
    state_e          state_q;
    logic [IDXW-1:0] lock_q;
    logic            last_q;

    assign w   = (state_q == LOCKED) ? lock_q : scan_w;
    assign any = (state_q == LOCKED) ? valid_up_in[lock_q] : scan_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            last_q  <= 1'b0;
        end else if (up_fire) begin
            state_q <= last_up_in[w] ? IDLE : LOCKED;
            lock_q  <= w;
            last_q  <= last_up_in[w];
        end
    end

    assign last_down_out = last_q;
`else
    assign w   = scan_w;
    assign any = scan_any;
`endif

    assign load_en      = ~valid_q | ready_down_in;
    assign up_fire      = any & load_en;
    assign ready_up_out = (up_fire & rst_n) ? ({{(N-1){1'b0}}, 1'b1} << w) : '0;
    assign ptr_d        = (w == IDXW'(N - 1)) ? '0 : w + 1'b1;

    // While locked w is the locked index, so ptr settles at lock_idx+1 on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (up_fire) begin
            data_q  <= data_in[int'(w)*WIDTH +: WIDTH];
            valid_q <= 1'b1;
            idx_q   <= w;
            ptr_q   <= ptr_d;
        end else if (ready_down_in) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out       = data_q;
    assign valid_down_out = valid_q;
    assign grant_idx      = idx_q;
endmodule
